// File: rtl/call_stack_if.sv
// Bundle of control inputs and status outputs for the call_stack return-address/data stack.
// The controller drives push/pop/clear/stall as level commands sampled on the rising edge.
interface call_stack_if #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              stall;
  logic              clear;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic [DATA_W-1:0] top;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output stall, clear, push, pop, push_data, err_clr,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  stall, clear, push, pop, push_data, err_clr,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Parametrised LIFO for return addresses/data with drop or wrap-on-full policy,
// stall hold, synchronous clear and sticky overflow/underflow flags.
module call_stack #(
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  call_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_sp_m1;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_sp_nxt;
  logic [PTR_W:0]    w_cnt_nxt;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_addr;
  logic              w_set_ovf;
  logic              w_set_unf;

  assign w_sp_m1 = r_sp - SP_ONE;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_MAX);

  // Command decode. Priority is stall > clear > push/pop; push&pop on a
  // non-empty stack rewrites the top slot in place.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_count;
    w_wr_en   = 1'b0;
    w_wr_addr = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (!bus.stall) begin
      if (bus.clear) begin
        w_sp_nxt  = '0;
        w_cnt_nxt = '0;
      end else if (bus.push && bus.pop) begin
        w_wr_en = 1'b1;
        if (w_empty) begin
          w_sp_nxt  = r_sp + SP_ONE;
          w_cnt_nxt = CNT_ONE;
          w_set_unf = 1'b1;
        end else begin
          w_wr_addr = w_sp_m1;
        end
      end else if (bus.push) begin
        if (!w_full) begin
          w_wr_en   = 1'b1;
          w_sp_nxt  = r_sp + SP_ONE;
          w_cnt_nxt = r_count + CNT_ONE;
        end else begin
          w_set_ovf = 1'b1;
          if (WRAP_MODE != 0) begin
            w_wr_en  = 1'b1;
            w_sp_nxt = r_sp + SP_ONE;
          end
        end
      end else if (bus.pop) begin
        if (!w_empty) begin
          w_sp_nxt  = w_sp_m1;
          w_cnt_nxt = r_count - CNT_ONE;
        end else begin
          w_set_unf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!bus.stall) begin
      r_sp    <= w_sp_nxt;
      r_count <= w_cnt_nxt;
      // A fresh error in the same cycle as err_clr keeps the flag set.
      r_ovf   <= (r_ovf & ~bus.err_clr) | w_set_ovf;
      r_unf   <= (r_unf & ~bus.err_clr) | w_set_unf;
    end
  end

  // Entry storage is intentionally not reset; only sp/count define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= bus.push_data;
    end
  end

  assign bus.top       = w_empty ? '0 : r_mem[w_sp_m1];
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: three instances (8/drop, 4/drop, 4/wrap) share one random
// command stream and are compared each cycle against queue-based stack models.
module tb_call_stack;
  typedef logic [11:0] q_t[$];

  logic clk;
  logic reset;
  logic        d_stall, d_clear, d_push, d_pop, d_errc;
  logic [11:0] d_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  q_t  m_q0, m_q1, m_q2;
  bit  m_ov [3];
  bit  m_un [3];
  logic [11:0] exp_q[$];
  logic [11:0] exp_q2[$];

  call_stack_if #(.DATA_W(12), .DEPTH(8)) if0 ();
  call_stack_if #(.DATA_W(12), .DEPTH(4)) if1 ();
  call_stack_if #(.DATA_W(12), .DEPTH(4)) if2 ();

  assign if0.stall = d_stall; assign if0.clear = d_clear; assign if0.push = d_push;
  assign if0.pop = d_pop; assign if0.err_clr = d_errc; assign if0.push_data = d_data;
  assign if1.stall = d_stall; assign if1.clear = d_clear; assign if1.push = d_push;
  assign if1.pop = d_pop; assign if1.err_clr = d_errc; assign if1.push_data = d_data;
  assign if2.stall = d_stall; assign if2.clear = d_clear; assign if2.push = d_push;
  assign if2.pop = d_pop; assign if2.err_clr = d_errc; assign if2.push_data = d_data;

  call_stack #(.DATA_W(12), .DEPTH(8), .WRAP_MODE(0)) u_s0 (.clk(clk), .reset(reset), .bus(if0));
  call_stack #(.DATA_W(12), .DEPTH(4), .WRAP_MODE(0)) u_s1 (.clk(clk), .reset(reset), .bus(if1));
  call_stack #(.DATA_W(12), .DEPTH(4), .WRAP_MODE(1)) u_s2 (.clk(clk), .reset(reset), .bus(if2));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the back of the queue is the top of stack.
  function automatic void model_step(inout q_t q, inout bit ov, inout bit un,
                                     input int depth, input bit wrap);
    bit new_ov = 1'b0;
    bit new_un = 1'b0;
    if (d_stall) return;
    if (d_clear) begin
      q.delete();
    end else if (d_push && d_pop) begin
      if (q.size() == 0) begin
        q.push_back(d_data);
        new_un = 1'b1;
      end else begin
        q[q.size()-1] = d_data;
      end
    end else if (d_push) begin
      if (q.size() < depth) begin
        q.push_back(d_data);
      end else begin
        new_ov = 1'b1;
        if (wrap) begin
          void'(q.pop_front());
          q.push_back(d_data);
        end
      end
    end else if (d_pop) begin
      if (q.size() == 0) new_un = 1'b1;
      else void'(q.pop_back());
    end
    ov = (ov && !d_errc) || new_ov;
    un = (un && !d_errc) || new_un;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q0.delete(); m_q1.delete(); m_q2.delete();
      for (int k = 0; k < 3; k++) begin
        m_ov[k] = 1'b0;
        m_un[k] = 1'b0;
      end
    end else begin
      model_step(m_q0, m_ov[0], m_un[0], 8, 1'b0);
      model_step(m_q1, m_ov[1], m_un[1], 4, 1'b0);
      model_step(m_q2, m_ov[2], m_un[2], 4, 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input logic [11:0] top, input logic [31:0] cnt,
                            input logic emp, input logic full, input logic ov, input logic un,
                            input q_t q, input bit mov, input bit mun, input int depth);
    int sz;
    logic [11:0] etop;
    sz = q.size();
    etop = (sz == 0) ? 12'h000 : q[sz-1];
    chk({nm, ".top"},   32'(top),  32'(etop));
    chk({nm, ".count"}, cnt,       32'(sz));
    chk({nm, ".empty"}, 32'(emp),  32'(sz == 0));
    chk({nm, ".full"},  32'(full), 32'(sz == depth));
    chk({nm, ".ovf"},   32'(ov),   32'(mov));
    chk({nm, ".unf"},   32'(un),   32'(mun));
  endtask

  // Scoreboard compare, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("i0", if0.top, 32'(if0.count), if0.empty, if0.full, if0.overflow,
                 if0.underflow, m_q0, m_ov[0], m_un[0], 8);
      check_inst("i1", if1.top, 32'(if1.count), if1.empty, if1.full, if1.overflow,
                 if1.underflow, m_q1, m_ov[1], m_un[1], 4);
      check_inst("i2", if2.top, 32'(if2.count), if2.empty, if2.full, if2.overflow,
                 if2.underflow, m_q2, m_ov[2], m_un[2], 4);
    end
  end

  // Driver: apply one command for one edge, then return to idle.
  task automatic op(input bit s, input bit c, input bit pu, input bit po, input bit e,
                    input logic [11:0] d);
    @(negedge clk);
    d_stall = s; d_clear = c; d_push = pu; d_pop = po; d_errc = e; d_data = d;
    @(posedge clk);
    #1;
    d_stall = 0; d_clear = 0; d_push = 0; d_pop = 0; d_errc = 0; d_data = '0;
  endtask

  task automatic push(input logic [11:0] d); op(0, 0, 1, 0, 0, d); endtask
  task automatic pop();                      op(0, 0, 0, 1, 0, 12'h000); endtask
  task automatic clr();                      op(0, 1, 0, 0, 0, 12'h000); endtask

  initial begin
    d_stall = 0; d_clear = 0; d_push = 0; d_pop = 0; d_errc = 0; d_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst.count", 32'(if0.count), 32'd0);
    chk("rst.empty", 32'(if0.empty), 32'd1);

    // Asynchronous reset mid-run with three entries.
    push(12'h111); push(12'h222); push(12'h333);
    chk("t2.top3", 32'(if0.top), 32'h333);
    chk("t2.cnt3", 32'(if0.count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("t1.count", 32'(if0.count), 32'd0);
    chk("t1.empty", 32'(if0.empty), 32'd1);
    chk("t1.top",   32'(if0.top), 32'd0);
    chk("t1.flags", 32'({if0.overflow, if0.underflow}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    push(12'h111); push(12'h222); push(12'h333);
    exp_q = '{12'h222, 12'h111, 12'h000};
    for (int i = 0; i < 3; i++) begin
      pop();
      chk("t2.pop_top", 32'(if0.top), 32'(exp_q.pop_front()));
    end
    chk("t2.empty", 32'(if0.empty), 32'd1);

    // Drop vs wrap on a 4-deep stack.
    clr();
    for (int i = 1; i <= 5; i++) push(12'(i));
    chk("t3.full", 32'(if1.full), 32'd1);
    chk("t3.ovf",  32'(if1.overflow), 32'd1);
    chk("t3.top",  32'(if1.top), 32'h4);
    chk("t4.cnt",  32'(if2.count), 32'd4);
    chk("t4.ovf",  32'(if2.overflow), 32'd1);
    exp_q  = '{12'h4, 12'h3, 12'h2, 12'h1};
    exp_q2 = '{12'h5, 12'h4, 12'h3, 12'h2};
    for (int i = 0; i < 4; i++) begin
      chk("t3.pop_val", 32'(if1.top), 32'(exp_q.pop_front()));
      chk("t4.pop_val", 32'(if2.top), 32'(exp_q2.pop_front()));
      pop();
    end
    chk("t3.empty", 32'(if1.empty), 32'd1);
    chk("t4.empty", 32'(if2.empty), 32'd1);

    // Replace-top and push&pop on empty.
    op(0, 0, 0, 0, 1, 12'h000);
    clr();
    push(12'h011); push(12'h0AA);
    op(0, 0, 1, 1, 0, 12'h0BB);
    chk("t5.top", 32'(if0.top), 32'h0BB);
    chk("t5.cnt", 32'(if0.count), 32'd2);
    chk("t5.unf0", 32'(if0.underflow), 32'd0);
    clr();
    op(0, 0, 1, 1, 0, 12'h0CC);
    chk("t5.e_cnt", 32'(if0.count), 32'd1);
    chk("t5.e_top", 32'(if0.top), 32'h0CC);
    chk("t5.e_unf", 32'(if0.underflow), 32'd1);

    // Stall holds everything, including the error flags.
    for (int i = 0; i < 3; i++) op(1, 1, 1, 1, 1, 12'hFFF);
    chk("t6.cnt", 32'(if0.count), 32'd1);
    chk("t6.top", 32'(if0.top), 32'h0CC);
    chk("t6.unf", 32'(if0.underflow), 32'd1);
    clr();
    op(0, 0, 0, 1, 1, 12'h000);
    chk("t6.unf_win", 32'(if0.underflow), 32'd1);
    op(0, 0, 0, 0, 1, 12'h000);
    chk("t6.unf_clr", 32'(if0.underflow), 32'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      op($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
         $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
         $urandom_range(0, 9) == 0, 12'($urandom_range(0, 4095)));
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
